// File: rtl/anfsqrt_seqctl.sv
// anfsqrt_seqctl: fixed-latency sequential integer square root, one root bit per clock
module anfsqrt_seqctl #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_rad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH/2-1:0]  out_root,
  output logic [WIDTH/2:0]    out_rem,
  output logic                busy
);
  localparam int RW = WIDTH / 2;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] rad_q;
  logic [RW-1:0]    res_q;
  logic [IW-1:0]    idx_q;
  logic [RW-1:0]    root_q;
  logic [RW:0]      rem_q;
  logic [RW-1:0]    att;
  logic [RW-1:0]    res_d;
  logic [WIDTH-1:0] sq;
  logic [WIDTH-1:0] rem_d;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_root  = root_q;
  assign out_rem   = rem_q;
  // trial bit for this step; att < 2^RW so its square never overflows WIDTH bits
  always_comb begin
    att   = res_q | (RW'(1) << idx_q);
    sq    = WIDTH'(att) * WIDTH'(att);
    res_d = (sq <= rad_q) ? att : res_q;
    rem_d = rad_q - WIDTH'(res_d) * WIDTH'(res_d);
  end
  // control FSM and iteration registers; result registered on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          rad_q   <= in_rad;
          res_q   <= '0;
          idx_q   <= IW'(RW - 1);
          state_q <= RUN;
        end
        RUN: begin
          res_q <= res_d;
          if (idx_q == '0) begin
            state_q <= DONE;
            root_q  <= res_d;
            rem_q   <= rem_d[RW:0];
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/anfsqrt_seqctl.md
Name: anfsqrt_seqctl

Overview:
- Sequential integer square-root engine that drives the ANF-SQRT successive-approximation step.
- Accepts a radicand over a valid/ready handshake and performs one attempt per clock, most-significant root bit first.
- Returns the floor root and the remainder over a valid/ready handshake.
- Sits directly upstream of, and owns, the iteration datapath. It replaces free-running, bench-driven iteration with a controlled, fixed-latency operation.

Parameters:
- WIDTH, 32, radicand width in bits. Must be even and at least 4.
- RW, WIDTH/2, root width. Derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  radicand offered.
- in_ready  out  1  engine can accept a radicand.
- in_rad  in  WIDTH  radicand, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_root  out  RW  floor(sqrt(in_rad)).
- out_rem  out  RW+1  in_rad - out_root^2.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async assert, effective immediately):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_root=0; out_rem=0; internal rad/res/idx cleared.
  - Reset mid-RUN or mid-DONE aborts the operation. No result is emitted.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state==RUN).
- IDLE:
  - On in_valid & in_ready: latch rad<=in_rad, res<=0, idx<=RW-1, go RUN.
  - Otherwise hold. out_root/out_rem keep the previous result.
- RUN: one step per cycle.
  - att = res | (1<<idx).
  - If att*att <= rad (compare at WIDTH bits, unsigned, product full width, no overflow since att < 2^RW), then res<=att.
  - If idx==0: go DONE, and register out_root<=final res and out_rem<=rad - final res^2, both computed from the step result of this cycle.
  - Else idx<=idx-1.
- Latency:
  - Acceptance at edge k. Bits RW-1..0 are processed at edges k+1..k+RW.
  - out_valid rises after edge k+RW: 16 cycles for WIDTH=32. Fixed and data-independent.
- DONE:
  - out_root/out_rem stable while out_valid=1.
  - On out_ready: go IDLE at that edge. in_ready is high the next cycle.
  - out_valid=0 from then on; the data outputs hold their values.
- Simultaneous events:
  - in_valid is ignored while state is not IDLE (no queuing).
  - in_rad changing during RUN has no effect.
  - out_ready while not in DONE is ignored.
  - No same-cycle DONE->accept bypass; the minimum issue interval is RW+2 cycles.
- Arithmetic:
  - All operations unsigned.
  - out_rem is at most 2*out_root, so it fits in RW+1 bits.

Test Plan:
- in_rad=65536, out_ready=1 -> out_valid 16 cycles after acceptance, out_root=256, out_rem=0; busy high exactly 16 cycles.
- in_rad=0 -> out_root=0, out_rem=0. in_rad=99 -> out_root=9, out_rem=18. in_rad=1 -> out_root=1, out_rem=0.
- in_rad=0xFFFFFFFF -> out_root=0xFFFF, out_rem=0x1FFFE. in_rad=0xFFFE0001 -> out_root=0xFFFF, out_rem=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, and an in_valid pulse with in_rad=4 is ignored. Then out_ready=1 -> IDLE next cycle; in_rad=4 is then accepted -> out_root=2, out_rem=0.
- Assert rst at RUN step 8 for in_rad=1000 -> all outputs 0 immediately, in_ready=1 after release, no out_valid. A fresh in_rad=1000 then yields out_root=31, out_rem=39.
- Back-to-back: 200 random radicands with random out_ready stalls -> each result matches floor sqrt and the remainder from a model; no drops or duplicates.
